mop_queue: RTL and testbench
============================

Name: mop_queue

Overview:
- Micro-op buffer between the decoder and the register-read stage.
- The decoder cracks one fat instruction into up to two micro_op_t per cycle (e.g. m_ld followed by m_add) and pushes them here.
- Register-read pops one micro op per cycle.
- The queue decouples decoder bursts from back-end stalls, supports a full flush on taken jump or syscall, and flags jump-class micro ops at its output.

Parameters:
- DEPTH, 8, number of micro_op_t entries; must be a power of two and >= 4.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter; derived, not overridden.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enq_valid0  in  1  slot 0 carries a micro op this cycle.
- enq_mop0  in  $bits(micro_op_t)  first micro op of the instruction (program order older).
- enq_valid1  in  1  slot 1 carries a micro op; honoured only when enq_valid0=1.
- enq_mop1  in  $bits(micro_op_t)  second micro op (younger).
- enq_ready  out  1  queue can accept two entries this cycle.
- deq_valid  out  1  head entry valid.
- deq_mop  out  $bits(micro_op_t)  head entry.
- deq_is_jump  out  1  head opcode strictly between M_JMIN and M_JMAX.
- deq_is_syscall  out  1  head opcode == m_syscall.
- deq_ready  in  1  consumer takes head this cycle.
- flush  in  1  discard all entries.
- count  out  CNT_W  current occupancy.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n=0, any time including mid-burst): head=0, tail=0, count=0. Outputs go to enq_ready=1, deq_valid=0, deq_is_jump=0, deq_is_syscall=0. deq_mop is don't-care but must not be X-driven into deq_valid. Storage array is not cleared.
- Enqueue handshake: enq_ready = (count <= DEPTH-2). It is computed from registered count only and does not depend on deq_ready in the same cycle (no combinational path input-to-ready).
- n_enq = 0 if !enq_ready or !enq_valid0; 1 if enq_valid0 && !enq_valid1; 2 if both valid.
- Enqueue is all-or-nothing per instruction. The decoder holds both slots until a cycle with enq_ready=1.
- Writes: mem[tail] <= enq_mop0. If n_enq=2, also mem[tail+1] <= enq_mop1. Then tail <= tail + n_enq, with pointer arithmetic modulo DEPTH (wrap-around: tail=DEPTH-1 with n_enq=2 writes entries DEPTH-1 and 0).
- Dequeue: deq_valid = (count != 0). deq_mop = mem[head], read combinationally from registered storage. Pop occurs when deq_valid && deq_ready; head <= head+1 mod DEPTH. deq_ready with count=0 is ignored.
- Latency: an entry enqueued in cycle N is visible on deq_mop in cycle N+1 at the earliest. There is no bypass path.
- Count update: count <= count + n_enq - pop. Simultaneous enq and deq are legal at any occupancy allowed by enq_ready.
- Flush: takes priority over everything in the same cycle. head <= 0, tail <= 0, count <= 0; that cycle's enqueue and pop are both discarded. deq_valid=0 from the next cycle.
- Decode flags: deq_is_jump = deq_valid && (deq_mop.opcode > M_JMIN) && (deq_mop.opcode < M_JMAX). deq_is_syscall = deq_valid && deq_mop.opcode == m_syscall. Both are combinational from the head entry.
- Order: strict FIFO; slot 0 is always older than slot 1 of the same cycle.
- Assertions (bench): count never exceeds DEPTH; no write when count > DEPTH-2; enq_valid1 without enq_valid0 never changes state.

Test Plan:
- Reset then single enqueue: enq_valid0=1 with m_add, cycle 1 -> cycle 2 deq_valid=1, deq_mop.opcode=m_add, count=1, deq_is_jump=0.
- Dual enqueue plus order: push {m_ld, m_add} with deq_ready=0 -> count=2. Then deq_ready=1 for 2 cycles -> m_ld then m_add popped, count returns to 0, deq_valid=0.
- Fill and backpressure (DEPTH=8): push pairs, deq_ready=0 -> enq_ready=1 at count 0,2,4,6; at count=6 the pair is accepted, count=8, enq_ready=0. Further valid pairs are dropped and count stays 8.
- Wrap and simultaneous enq/deq: preload 7 entries, pop continuously while pushing pairs for 10 cycles -> count tracks +1 per cycle, capped by enq_ready. Output sequence is exactly the pushed sequence across the tail wrap at index 7->0.
- Flush priority: count=5, assert flush together with a valid pair and deq_ready=1 -> next cycle count=0, deq_valid=0. Next push of m_jnb appears at head with deq_is_jump=1.
- Async reset mid-op: count=4, drop reset_n between clock edges -> count=0, deq_valid=0 immediately without a clock edge. After release, an m_syscall push gives deq_is_syscall=1 one cycle later.

Source files
------------

// File: rtl/mop_queue.sv
// Dual-push / single-pop micro-op queue between decode and register-read; 1 cycle enq->deq, no bypass.
// Backpressure: enq_ready drops when fewer than two slots are free (registered count only); flush wins over all.
package mop_pkg;
    typedef enum logic [4:0] {
        m_nop, m_add, m_sub, m_ld, m_st,
        M_JMIN, m_jmp, m_jz, m_jnb, m_call, m_ret, M_JMAX,
        m_syscall
    } opcode_e;

    typedef struct packed {
        opcode_e     opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [15:0] imm;
    } micro_op_t;
endpackage

module mop_queue
    import mop_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enq_valid0,
    input  micro_op_t        enq_mop0,
    input  logic             enq_valid1,
    input  micro_op_t        enq_mop1,
    output logic             enq_ready,
    output logic             deq_valid,
    output micro_op_t        deq_mop,
    output logic             deq_is_jump,
    output logic             deq_is_syscall,
    input  logic             deq_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] RDY_MAX = CNT_W'(DEPTH - 2);

    micro_op_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [1:0]       n_enq;
    logic             pop;

    // Ready reserves room for a full pair so a cracked instruction is never split.
    assign enq_ready = (count <= RDY_MAX);
    assign deq_valid = (count != '0);
    assign deq_mop   = mem[head];
    assign pop       = deq_valid && deq_ready;

    assign deq_is_jump    = deq_valid && (deq_mop.opcode > M_JMIN) && (deq_mop.opcode < M_JMAX);
    assign deq_is_syscall = deq_valid && (deq_mop.opcode == m_syscall);

    always_comb begin
        n_enq = 2'd0;
        if (enq_ready && enq_valid0) begin
            n_enq = enq_valid1 ? 2'd2 : 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop);
            tail  <= tail + PTR_W'(n_enq);
            count <= count + CNT_W'(n_enq) - CNT_W'(pop);
        end
    end

    // Storage is left unreset; validity is carried entirely by count.
    always_ff @(posedge clk) begin
        if (!flush && (n_enq != 2'd0)) begin
            mem[tail] <= enq_mop0;
            if (n_enq == 2'd2) begin
                mem[tail + PTR_W'(1)] <= enq_mop1;
            end
        end
    end
endmodule

// File: tb/tb_mop_queue.sv
// Bench for mop_queue: directed vector table, multi-cycle corner sequences and randomized traffic vs a queue model.
module tb_mop_queue;
    import mop_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset_n;
    logic             enq_valid0;
    micro_op_t        enq_mop0;
    logic             enq_valid1;
    micro_op_t        enq_mop1;
    logic             enq_ready;
    logic             deq_valid;
    micro_op_t        deq_mop;
    logic             deq_is_jump;
    logic             deq_is_syscall;
    logic             deq_ready;
    logic             flush;
    logic [CNT_W-1:0] count;

    mop_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enq_valid0     (enq_valid0),
        .enq_mop0       (enq_mop0),
        .enq_valid1     (enq_valid1),
        .enq_mop1       (enq_mop1),
        .enq_ready      (enq_ready),
        .deq_valid      (deq_valid),
        .deq_mop        (deq_mop),
        .deq_is_jump    (deq_is_jump),
        .deq_is_syscall (deq_is_syscall),
        .deq_ready      (deq_ready),
        .flush          (flush),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int sn    = 0;
    micro_op_t mq[$];

    typedef struct {
        bit      v0;
        bit      v1;
        opcode_e op0;
        opcode_e op1;
        bit      dr;
        bit      fl;
        int      ecnt;
        bit      evld;
        opcode_e eop;
        bit      ejmp;
        bit      esys;
        bit      erdy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic micro_op_t mk_mop(input opcode_e op);
        micro_op_t m;
        m.opcode = op;
        m.rd     = 5'(sn);
        m.rs1    = 5'($urandom_range(0, 31));
        m.rs2    = 5'($urandom_range(0, 31));
        m.imm    = 16'(sn);
        sn++;
        return m;
    endfunction

    function automatic bit is_jump_op(input opcode_e op);
        return op inside {m_jmp, m_jz, m_jnb, m_call, m_ret};
    endfunction

    function automatic vec_t mkv(input bit v0, input bit v1, input opcode_e op0, input opcode_e op1,
                                 input bit dr, input bit fl, input int ecnt, input bit evld,
                                 input opcode_e eop, input bit ejmp, input bit esys, input bit erdy);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.op0 = op0; v.op1 = op1; v.dr = dr; v.fl = fl;
        v.ecnt = ecnt; v.evld = evld; v.eop = eop; v.ejmp = ejmp; v.esys = esys; v.erdy = erdy;
        return v;
    endfunction

    task automatic drive(input bit v0, input bit v1, input opcode_e op0, input opcode_e op1,
                         input bit dr, input bit fl);
        enq_valid0 = v0;
        enq_valid1 = v1;
        enq_mop0   = mk_mop(op0);
        enq_mop1   = mk_mop(op1);
        deq_ready  = dr;
        flush      = fl;
    endtask

    task automatic compare_model();
        chk("count", 64'(count), 64'(mq.size()));
        chk("count_le_depth", 64'(count <= DEPTH), 64'd1);
        chk("deq_valid", 64'(deq_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("deq_mop", 64'(deq_mop), 64'(mq[0]));
            chk("deq_is_jump", 64'(deq_is_jump), 64'(is_jump_op(mq[0].opcode)));
            chk("deq_is_syscall", 64'(deq_is_syscall), 64'(mq[0].opcode == m_syscall));
        end else begin
            chk("deq_is_jump_empty", 64'(deq_is_jump), 64'd0);
            chk("deq_is_syscall_empty", 64'(deq_is_syscall), 64'd0);
        end
    endtask

    // One clock: model advances with the inputs present before the edge, outputs checked 1ns after it.
    task automatic tick(input bit check_model);
        bit rdy_m;
        rdy_m = (mq.size() <= DEPTH - 2);
        if (check_model) begin
            chk("enq_ready", 64'(enq_ready), 64'(rdy_m));
        end
        if (flush) begin
            mq.delete();
        end else begin
            if (deq_ready && mq.size() != 0) void'(mq.pop_front());
            if (rdy_m && enq_valid0) begin
                mq.push_back(enq_mop0);
                if (enq_valid1) mq.push_back(enq_mop1);
            end
        end
        @(posedge clk);
        #1;
        if (check_model) compare_model();
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, m_nop, m_nop, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_deq_valid", 64'(deq_valid), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_jump", 64'(deq_is_jump), 64'd0);
        chk("rst_syscall", 64'(deq_is_syscall), 64'd0);
        reset_n = 1'b1;

        tbl.push_back(mkv(1, 0, m_add,    m_nop,     0, 0, 1, 1, m_add,     0, 0, 1));
        tbl.push_back(mkv(0, 0, m_nop,    m_nop,     1, 0, 0, 0, m_nop,     0, 0, 1));
        tbl.push_back(mkv(1, 1, m_ld,     m_add,     0, 0, 2, 1, m_ld,      0, 0, 1));
        tbl.push_back(mkv(0, 0, m_nop,    m_nop,     1, 0, 1, 1, m_add,     0, 0, 1));
        tbl.push_back(mkv(0, 0, m_nop,    m_nop,     1, 0, 0, 0, m_nop,     0, 0, 1));
        tbl.push_back(mkv(1, 1, m_jz,     m_syscall, 0, 0, 2, 1, m_jz,      1, 0, 1));
        tbl.push_back(mkv(1, 1, m_add,    m_sub,     0, 0, 4, 1, m_jz,      1, 0, 1));
        tbl.push_back(mkv(1, 1, m_ld,     m_st,      0, 0, 6, 1, m_jz,      1, 0, 1));
        tbl.push_back(mkv(1, 1, m_add,    m_add,     0, 0, 8, 1, m_jz,      1, 0, 0));
        tbl.push_back(mkv(1, 1, m_jmp,    m_jmp,     0, 0, 8, 1, m_jz,      1, 0, 0));
        tbl.push_back(mkv(1, 1, m_add,    m_add,     1, 1, 0, 0, m_nop,     0, 0, 1));
        tbl.push_back(mkv(1, 0, m_jnb,    m_nop,     0, 0, 1, 1, m_jnb,     1, 0, 1));
        tbl.push_back(mkv(1, 0, m_syscall, m_nop,    1, 0, 1, 1, m_syscall, 0, 1, 1));
        tbl.push_back(mkv(0, 1, m_nop,    m_ld,      0, 0, 1, 1, m_syscall, 0, 1, 1));
        tbl.push_back(mkv(0, 0, m_nop,    m_nop,     1, 0, 0, 0, m_nop,     0, 0, 1));
        tbl.push_back(mkv(1, 1, M_JMIN,   M_JMAX,    0, 0, 2, 1, M_JMIN,    0, 0, 1));
        tbl.push_back(mkv(0, 0, m_nop,    m_nop,     1, 0, 1, 1, M_JMAX,    0, 0, 1));
        tbl.push_back(mkv(0, 0, m_nop,    m_nop,     1, 0, 0, 0, m_nop,     0, 0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].v0, tbl[i].v1, tbl[i].op0, tbl[i].op1, tbl[i].dr, tbl[i].fl);
            tick(0);
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].ecnt));
            chk($sformatf("vec%0d_valid", i), 64'(deq_valid), 64'(tbl[i].evld));
            if (tbl[i].evld) chk($sformatf("vec%0d_op", i), 64'(deq_mop.opcode), 64'(tbl[i].eop));
            chk($sformatf("vec%0d_jump", i), 64'(deq_is_jump), 64'(tbl[i].ejmp));
            chk($sformatf("vec%0d_sys", i), 64'(deq_is_syscall), 64'(tbl[i].esys));
            chk($sformatf("vec%0d_rdy", i), 64'(enq_ready), 64'(tbl[i].erdy));
        end

        // Flush at occupancy 5 beats a simultaneous pair and pop.
        drive(1, 1, m_add, m_sub, 0, 0); tick(1);
        drive(1, 1, m_ld,  m_st,  0, 0); tick(1);
        drive(1, 0, m_add, m_nop, 0, 0); tick(1);
        chk("pre_flush_count", 64'(count), 64'd5);
        drive(1, 1, m_add, m_add, 1, 1); tick(1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(deq_valid), 64'd0);
        drive(1, 0, m_jnb, m_nop, 0, 0); tick(1);
        chk("jnb_jump", 64'(deq_is_jump), 64'd1);
        drive(0, 0, m_nop, m_nop, 1, 0); tick(1);

        // Preload 7, then pop every cycle while offering pairs across the pointer wrap.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, m_add, m_sub, 0, 0); tick(1);
        end
        drive(1, 0, m_ld, m_nop, 0, 0); tick(1);
        chk("preload_count", 64'(count), 64'd7);
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, opcode_e'($urandom_range(0, 12)), opcode_e'($urandom_range(0, 12)), 1, 0);
            tick(1);
        end
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(0, 0, m_nop, m_nop, 1, 0); tick(1);
        end
        chk("drain_count", 64'(count), 64'd0);

        // Asynchronous reset between clock edges.
        drive(1, 1, m_add, m_ld, 0, 0); tick(1);
        drive(1, 1, m_st,  m_ld, 0, 0); tick(1);
        drive(0, 0, m_nop, m_nop, 0, 0);
        chk("pre_arst_count", 64'(count), 64'd4);
        #3;
        reset_n = 1'b0;
        mq.delete();
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(deq_valid), 64'd0);
        chk("arst_ready", 64'(enq_ready), 64'd1);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 0, m_syscall, m_nop, 0, 0); tick(1);
        chk("post_arst_syscall", 64'(deq_is_syscall), 64'd1);
        drive(0, 0, m_nop, m_nop, 1, 0); tick(1);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  opcode_e'($urandom_range(0, 12)), opcode_e'($urandom_range(0, 12)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
            tick(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
